// File: rtl/sh7604_intc_if.sv
// IBUS register port and CPU interrupt handshake of the SH7604 interrupt controller.
interface sh7604_intc_if;
  logic [31:0] IBUS_A;
  logic [31:0] IBUS_DI;
  logic [31:0] IBUS_DO;
  logic [3:0]  IBUS_BA;
  logic        IBUS_WE;
  logic        IBUS_REQ;
  logic        IBUS_BUSY;
  logic        IBUS_ACT;
  logic [3:0]  INT_MASK;
  logic        INT_REQ;
  logic        INT_NMI;
  logic [3:0]  INT_LVL;
  logic [7:0]  INT_VEC;
  logic        INT_ACK;

  modport master (
    output IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ, INT_MASK, INT_ACK,
    input  IBUS_DO, IBUS_BUSY, IBUS_ACT, INT_REQ, INT_NMI, INT_LVL, INT_VEC
  );

  modport slave (
    input  IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ, INT_MASK, INT_ACK,
    output IBUS_DO, IBUS_BUSY, IBUS_ACT, INT_REQ, INT_NMI, INT_LVL, INT_VEC
  );
endinterface

// File: rtl/sh7604_intc.sv
// SH7604 interrupt controller: ICR/IPRA/IPRB registers, NMI edge capture,
// priority arbitration and a REQ/ACK handshake towards the CPU core.
module sh7604_intc #(
  parameter logic [7:0]  NMI_VEC = 8'd11,
  parameter int unsigned IBUS_ZW = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE_R,
  input  logic       CE_F,
  input  logic       EN,
  input  logic       RES_N,
  input  logic       NMI_N,
  input  logic       DIVU_IRQ,
  input  logic       DMAC0_IRQ,
  input  logic       DMAC1_IRQ,
  input  logic       WDT_IRQ,
  input  logic       SCI_IRQ,
  input  logic       FRT_IRQ,
  input  logic [7:0] DIVU_VEC,
  input  logic [7:0] DMAC0_VEC,
  input  logic [7:0] DMAC1_VEC,
  input  logic [7:0] WDT_VEC,
  input  logic [7:0] SCI_VEC,
  input  logic [7:0] FRT_VEC,
  sh7604_intc_if.slave bus
);
  localparam int unsigned NSRC  = 6;
  localparam int unsigned SRC_W = 3;
  localparam logic [31:0] ICR_ADDR  = 32'hFFFF_FEE0;
  localparam logic [31:0] IPRB_ADDR = 32'hFFFF_FE60;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic               nmie_q, nmie_d;
  logic               vecmd_q, vecmd_d;
  logic [11:0]        ipra_q, ipra_d;
  logic [7:0]         iprb_q, iprb_d;
  logic               nmi_prev_q, nmi_vld_q;
  logic               nmi_pend_q, nmi_pend_d;
  logic               int_req_q, int_req_d;
  logic               int_nmi_q, int_nmi_d;
  logic [3:0]         int_lvl_q, int_lvl_d;
  logic [7:0]         int_vec_q, int_vec_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [31:0]        reg_do_q;

  logic               hit_icr, hit_iprb, act, wr_en, adv;
  logic               nmi_edge, nmi_clr;
  logic [31:0]        rd_data;
  logic [NSRC-1:0]    irq;
  logic [3:0]         lvl [NSRC];
  logic [7:0]         vec [NSRC];
  logic [3:0]         win_lvl;
  logic [7:0]         win_vec;
  logic [SRC_W-1:0]   win_idx;
  logic               unused_ok;

  assign hit_icr  = (bus.IBUS_A[31:2] == ICR_ADDR[31:2]);
  assign hit_iprb = (bus.IBUS_A[31:2] == IPRB_ADDR[31:2]);
  assign act      = hit_icr | hit_iprb;
  assign wr_en    = bus.IBUS_REQ & bus.IBUS_WE & act;
  assign adv      = CE_R & EN;

  assign bus.IBUS_ACT  = act;
  assign bus.IBUS_DO   = act ? reg_do_q : 32'h0;
  assign bus.IBUS_BUSY = (IBUS_ZW == 0) ? 1'b0 : 1'b0;
  assign bus.INT_REQ   = int_req_q;
  assign bus.INT_NMI   = int_nmi_q;
  assign bus.INT_LVL   = int_lvl_q;
  assign bus.INT_VEC   = int_vec_q;

  assign unused_ok = ^{bus.IBUS_DI[23:17], bus.IBUS_DI[3:0], bus.IBUS_A[1:0]};

  // Source table in fixed tie-break order; both DMAC channels share one field.
  always_comb begin
    irq = {FRT_IRQ, SCI_IRQ, WDT_IRQ, DMAC1_IRQ, DMAC0_IRQ, DIVU_IRQ};
    lvl[0] = ipra_q[11:8];
    lvl[1] = ipra_q[7:4];
    lvl[2] = ipra_q[7:4];
    lvl[3] = ipra_q[3:0];
    lvl[4] = iprb_q[7:4];
    lvl[5] = iprb_q[3:0];
    vec[0] = DIVU_VEC;
    vec[1] = DMAC0_VEC;
    vec[2] = DMAC1_VEC;
    vec[3] = WDT_VEC;
    vec[4] = SCI_VEC;
    vec[5] = FRT_VEC;
  end

  // Strict compare keeps the earlier source on equal levels; level 0 never wins.
  always_comb begin
    win_lvl = 4'h0;
    win_vec = 8'h00;
    win_idx = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (irq[i] && (lvl[i] > win_lvl)) begin
        win_lvl = lvl[i];
        win_vec = vec[i];
        win_idx = SRC_W'(i);
      end
    end
  end

  assign nmi_edge = CE_R & nmi_vld_q &
                    (nmie_q ? (~nmi_prev_q & NMI_N) : (nmi_prev_q & ~NMI_N));
  assign nmi_clr  = adv & (state_q == S_REQ) & bus.INT_ACK & int_nmi_q;

  always_comb begin
    rd_data = 32'h0;
    if (hit_icr) begin
      rd_data = {NMI_N, 6'b0, nmie_q, 7'b0, vecmd_q, ipra_q, 4'b0};
    end else if (hit_iprb) begin
      rd_data = {iprb_q, 24'h0};
    end
  end

  // Byte-lane register writes; the fields are big-endian halfwords of the word.
  always_comb begin
    nmie_d  = nmie_q;
    vecmd_d = vecmd_q;
    ipra_d  = ipra_q;
    iprb_d  = iprb_q;
    if (wr_en && hit_icr) begin
      if (bus.IBUS_BA[3]) nmie_d       = bus.IBUS_DI[24];
      if (bus.IBUS_BA[2]) vecmd_d      = bus.IBUS_DI[16];
      if (bus.IBUS_BA[1]) ipra_d[11:4] = bus.IBUS_DI[15:8];
      if (bus.IBUS_BA[0]) ipra_d[3:0]  = bus.IBUS_DI[7:4];
    end
    if (wr_en && hit_iprb && bus.IBUS_BA[3]) begin
      iprb_d = bus.IBUS_DI[31:24];
    end
  end

  // Request FSM; a new NMI edge wins over the acknowledge clearing the pending flag.
  always_comb begin
    state_d    = state_q;
    int_req_d  = int_req_q;
    int_nmi_d  = int_nmi_q;
    int_lvl_d  = int_lvl_q;
    int_vec_d  = int_vec_q;
    src_d      = src_q;
    nmi_pend_d = nmi_pend_q;
    if (adv) begin
      case (state_q)
        S_IDLE: begin
          if (nmi_pend_q) begin
            state_d   = S_REQ;
            int_req_d = 1'b1;
            int_nmi_d = 1'b1;
            int_lvl_d = 4'hF;
            int_vec_d = NMI_VEC;
          end else if (win_lvl > bus.INT_MASK) begin
            state_d   = S_REQ;
            int_req_d = 1'b1;
            int_nmi_d = 1'b0;
            int_lvl_d = win_lvl;
            int_vec_d = win_vec;
            src_d     = win_idx;
          end
        end
        S_REQ: begin
          if (bus.INT_ACK) begin
            state_d   = S_HOLD;
            int_req_d = 1'b0;
          end else if (!int_nmi_q && (!irq[src_q] || (int_lvl_q <= bus.INT_MASK))) begin
            state_d   = S_IDLE;
            int_req_d = 1'b0;
          end
        end
        S_HOLD: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d   = S_IDLE;
          int_req_d = 1'b0;
        end
      endcase
    end
    if (nmi_clr)  nmi_pend_d = 1'b0;
    if (nmi_edge) nmi_pend_d = 1'b1;
  end

  // Edge detector is qualified by nmi_vld_q so async reset cannot fake an edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      nmie_q     <= 1'b0;
      vecmd_q    <= 1'b0;
      ipra_q     <= '0;
      iprb_q     <= '0;
      nmi_prev_q <= 1'b0;
      nmi_vld_q  <= 1'b0;
      nmi_pend_q <= 1'b0;
      int_req_q  <= 1'b0;
      int_nmi_q  <= 1'b0;
      int_lvl_q  <= 4'h0;
      int_vec_q  <= 8'h00;
      src_q      <= '0;
      reg_do_q   <= 32'h0;
    end else if (CE_R && !RES_N) begin
      state_q    <= S_IDLE;
      nmie_q     <= 1'b0;
      vecmd_q    <= 1'b0;
      ipra_q     <= '0;
      iprb_q     <= '0;
      nmi_prev_q <= NMI_N;
      nmi_vld_q  <= 1'b1;
      nmi_pend_q <= 1'b0;
      int_req_q  <= 1'b0;
      int_nmi_q  <= 1'b0;
      int_lvl_q  <= 4'h0;
      int_vec_q  <= 8'h00;
      src_q      <= '0;
      reg_do_q   <= 32'h0;
    end else begin
      if (CE_R) begin
        state_q    <= state_d;
        nmie_q     <= nmie_d;
        vecmd_q    <= vecmd_d;
        ipra_q     <= ipra_d;
        iprb_q     <= iprb_d;
        nmi_prev_q <= NMI_N;
        nmi_vld_q  <= 1'b1;
        nmi_pend_q <= nmi_pend_d;
        int_req_q  <= int_req_d;
        int_nmi_q  <= int_nmi_d;
        int_lvl_q  <= int_lvl_d;
        int_vec_q  <= int_vec_d;
        src_q      <= src_d;
      end
      if (CE_F) begin
        reg_do_q <= rd_data;
      end
    end
  end
endmodule

// File: tb/tb_sh7604_intc.sv
// Directed bench for sh7604_intc: arbitration vector table plus handshake,
// NMI, register-map and reset sequences.
module tb_sh7604_intc;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CE_R = 1'b0;
  logic       CE_F = 1'b0;
  logic       EN = 1'b1;
  logic       RES_N = 1'b1;
  logic       NMI_N = 1'b1;
  logic [5:0] irq = 6'b0;

  int n_tests = 0;
  int n_fail  = 0;

  sh7604_intc_if bus ();

  sh7604_intc #(.NMI_VEC(8'd11), .IBUS_ZW(1)) dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F), .EN(EN), .RES_N(RES_N),
    .NMI_N(NMI_N),
    .DIVU_IRQ(irq[0]), .DMAC0_IRQ(irq[1]), .DMAC1_IRQ(irq[2]),
    .WDT_IRQ(irq[3]), .SCI_IRQ(irq[4]), .FRT_IRQ(irq[5]),
    .DIVU_VEC(8'h50), .DMAC0_VEC(8'h51), .DMAC1_VEC(8'h52),
    .WDT_VEC(8'h53), .SCI_VEC(8'h54), .FRT_VEC(8'h55),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] ipra;
    logic [15:0] iprb;
    logic [5:0]  irq;
    logic [3:0]  mask;
    logic        req;
    logic [3:0]  lvl;
    logic [7:0]  vec;
  } vec_t;

  vec_t tv [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One rising-phase clock followed by one falling-phase clock.
  task automatic step();
    CE_R = 1'b1;
    @(posedge CLK); #1;
    CE_R = 1'b0;
    CE_F = 1'b1;
    @(posedge CLK); #1;
    CE_F = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] ba, input logic [31:0] d);
    bus.IBUS_A = a; bus.IBUS_BA = ba; bus.IBUS_DI = d;
    bus.IBUS_WE = 1'b1; bus.IBUS_REQ = 1'b1;
    step();
    bus.IBUS_WE = 1'b0; bus.IBUS_REQ = 1'b0; bus.IBUS_A = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.IBUS_A = a; bus.IBUS_WE = 1'b0; bus.IBUS_REQ = 1'b1;
    step();
    d = bus.IBUS_DO;
    bus.IBUS_REQ = 1'b0; bus.IBUS_A = 32'h0;
  endtask

  task automatic soft_reset();
    irq = 6'b0; bus.INT_MASK = 4'h0; bus.INT_ACK = 1'b0;
    RES_N = 1'b0;
    step();
    RES_N = 1'b1;
  endtask

  task automatic ack();
    bus.INT_ACK = 1'b1;
    step();
    bus.INT_ACK = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    //               ipra      iprb      irq FSWDDD  mask req lvl  vec
    tv[0]  = '{16'hA000, 16'h0000, 6'b000001, 4'h3, 1'b1, 4'hA, 8'h50};
    tv[1]  = '{16'h5500, 16'h0000, 6'b000011, 4'h0, 1'b1, 4'h5, 8'h50};
    tv[2]  = '{16'h5500, 16'h0000, 6'b000110, 4'h0, 1'b1, 4'h5, 8'h51};
    tv[3]  = '{16'h0090, 16'h0000, 6'b001000, 4'hF, 1'b0, 4'h0, 8'h00};
    tv[4]  = '{16'h1230, 16'h4500, 6'b111111, 4'h0, 1'b1, 4'h5, 8'h55};
    tv[5]  = '{16'h1230, 16'h4500, 6'b111111, 4'h4, 1'b1, 4'h5, 8'h55};
    tv[6]  = '{16'h1230, 16'h4500, 6'b111111, 4'h5, 1'b0, 4'h0, 8'h00};
    tv[7]  = '{16'h0000, 16'h0000, 6'b111111, 4'h0, 1'b0, 4'h0, 8'h00};
    tv[8]  = '{16'h7770, 16'h7700, 6'b111111, 4'h6, 1'b1, 4'h7, 8'h50};
    tv[9]  = '{16'h0000, 16'h0F00, 6'b100000, 4'hE, 1'b1, 4'hF, 8'h55};
    tv[10] = '{16'h0000, 16'hF000, 6'b100000, 4'h0, 1'b0, 4'h0, 8'h00};
    tv[11] = '{16'h3300, 16'h0000, 6'b000100, 4'h2, 1'b1, 4'h3, 8'h52};

    bus.IBUS_A = 32'h0; bus.IBUS_DI = 32'h0; bus.IBUS_BA = 4'h0;
    bus.IBUS_WE = 1'b0; bus.IBUS_REQ = 1'b0; bus.INT_MASK = 4'h0; bus.INT_ACK = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req", 32'(bus.INT_REQ), 32'h0);
    chk("rst_nmi", 32'(bus.INT_NMI), 32'h0);
    chk("rst_lvl", 32'(bus.INT_LVL), 32'h0);
    chk("rst_vec", 32'(bus.INT_VEC), 32'h0);
    RST = 1'b0;
    step();
    chk("rst_busy", 32'(bus.IBUS_BUSY), 32'h0);
    rd(32'hFFFF_FEE0, d);
    chk("rst_icr_ipra", d, 32'h8000_0000);

    // Register map
    wr(32'hFFFF_FEE2, 4'b0011, 32'h0000_F0F0);
    rd(32'hFFFF_FEE2, d);
    chk("ipra_rd", 32'(d[15:0]), 32'h0000_F0F0);
    wr(32'hFFFF_FE60, 4'b1100, 32'h1234_0000);
    rd(32'hFFFF_FE60, d);
    chk("iprb_rd", 32'(d[31:16]), 32'h0000_1200);
    rd(32'hFFFF_FE62, d);
    chk("iprb_word", d, 32'h1200_0000);
    wr(32'hFFFF_FEE0, 4'b1100, 32'hFFFF_0000);
    rd(32'hFFFF_FEE0, d);
    chk("icr_rd", d, 32'h8101_F0F0);
    bus.IBUS_A = 32'hFFFF_FF00; bus.IBUS_REQ = 1'b1;
    step();
    chk("miss_act", 32'(bus.IBUS_ACT), 32'h0);
    chk("miss_do", bus.IBUS_DO, 32'h0);
    bus.IBUS_REQ = 1'b0; bus.IBUS_A = 32'h0;

    // Arbitration table
    for (int i = 0; i < 12; i++) begin
      soft_reset();
      wr(32'hFFFF_FEE0, 4'b0011, {16'h0, tv[i].ipra});
      wr(32'hFFFF_FE60, 4'b1100, {tv[i].iprb, 16'h0});
      irq = tv[i].irq;
      bus.INT_MASK = tv[i].mask;
      step();
      chk($sformatf("tv%0d_req", i), 32'(bus.INT_REQ), 32'(tv[i].req));
      chk($sformatf("tv%0d_lvl", i), 32'(bus.INT_LVL), 32'(tv[i].lvl));
      chk($sformatf("tv%0d_vec", i), 32'(bus.INT_VEC), 32'(tv[i].vec));
    end

    // DIVU request, frozen during priority write, ack, hold, re-request
    soft_reset();
    wr(32'hFFFF_FEE2, 4'b0011, 32'h0000_A000);
    bus.INT_MASK = 4'h3; irq[0] = 1'b1;
    step();
    chk("t1_req", 32'(bus.INT_REQ), 32'h1);
    chk("t1_lvl", 32'(bus.INT_LVL), 32'hA);
    chk("t1_vec", 32'(bus.INT_VEC), 32'h50);
    wr(32'hFFFF_FEE2, 4'b0011, 32'h0000_F000);
    chk("t1_frozen_lvl", 32'(bus.INT_LVL), 32'hA);
    ack();
    chk("t1_ack_req", 32'(bus.INT_REQ), 32'h0);
    step();
    chk("t1_hold_req", 32'(bus.INT_REQ), 32'h0);
    step();
    chk("t1_rereq", 32'(bus.INT_REQ), 32'h1);
    chk("t1_rereq_lvl", 32'(bus.INT_LVL), 32'hF);

    // Tie, withdrawal, then next source; EN freeze
    soft_reset();
    wr(32'hFFFF_FEE2, 4'b0011, 32'h0000_5500);
    irq[0] = 1'b1; irq[1] = 1'b1;
    step();
    chk("t2_vec", 32'(bus.INT_VEC), 32'h50);
    irq[0] = 1'b0;
    step();
    chk("t2_withdraw", 32'(bus.INT_REQ), 32'h0);
    step();
    chk("t2_next_req", 32'(bus.INT_REQ), 32'h1);
    chk("t2_next_vec", 32'(bus.INT_VEC), 32'h51);
    EN = 1'b0; irq[1] = 1'b0;
    step();
    chk("t2_en_hold", 32'(bus.INT_REQ), 32'h1);
    EN = 1'b1;
    step();
    chk("t2_en_withdraw", 32'(bus.INT_REQ), 32'h0);

    // Masked WDT, then NMI on falling edge
    soft_reset();
    wr(32'hFFFF_FEE2, 4'b0011, 32'h0000_0090);
    bus.INT_MASK = 4'hF; irq[3] = 1'b1;
    step();
    chk("t3_masked", 32'(bus.INT_REQ), 32'h0);
    NMI_N = 1'b0;
    step();
    step();
    chk("t3_nmi_req", 32'(bus.INT_REQ), 32'h1);
    chk("t3_nmi_flag", 32'(bus.INT_NMI), 32'h1);
    chk("t3_nmi_lvl", 32'(bus.INT_LVL), 32'hF);
    chk("t3_nmi_vec", 32'(bus.INT_VEC), 32'd11);
    ack();
    step();
    step();
    chk("t3_after_ack", 32'(bus.INT_REQ), 32'h0);

    // NMI edge coinciding with the acknowledge of a previous NMI
    NMI_N = 1'b1;
    step();
    NMI_N = 1'b0;
    step();
    step();
    chk("t6_first_nmi", 32'(bus.INT_NMI & bus.INT_REQ), 32'h1);
    NMI_N = 1'b1;
    step();
    NMI_N = 1'b0;
    ack();
    chk("t6_ack_req", 32'(bus.INT_REQ), 32'h0);
    step();
    chk("t6_hold_req", 32'(bus.INT_REQ), 32'h0);
    step();
    chk("t6_re_nmi", 32'(bus.INT_NMI & bus.INT_REQ), 32'h1);
    ack();
    step();
    step();
    chk("t6_cleared", 32'(bus.INT_REQ), 32'h0);

    // Async reset in the middle of an SCI request
    NMI_N = 1'b1;
    soft_reset();
    wr(32'hFFFF_FE60, 4'b1000, 32'h6000_0000);
    irq[4] = 1'b1;
    step();
    chk("t5_req", 32'(bus.INT_REQ), 32'h1);
    chk("t5_vec", 32'(bus.INT_VEC), 32'h54);
    #2 RST = 1'b1;
    #1;
    chk("t5_rst_req", 32'(bus.INT_REQ), 32'h0);
    chk("t5_rst_lvl", 32'(bus.INT_LVL), 32'h0);
    chk("t5_rst_vec", 32'(bus.INT_VEC), 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0; irq = 6'b0;
    rd(32'hFFFF_FEE0, d);
    chk("t5_ipra", 32'(d[15:0]), 32'h0);
    rd(32'hFFFF_FE60, d);
    chk("t5_iprb", 32'(d[31:16]), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sh7604_intc.md
Name: sh7604_intc

Overview:
- On-chip interrupt controller for the SH7604 core.
- Directly downstream of the DIVU and the other on-chip peripherals. It consumes their IRQ/VEC pairs plus the NMI pin.
- Arbitrates requests by the IPRA/IPRB priority fields and presents one level/vector request to the CPU core with an acknowledge handshake.
- Hosts ICR, IPRA and IPRB on the internal bus (IBUS).

Parameters:
NMI_VEC, 8'd11, vector number issued for NMI
IBUS_ZW, 1, 1 = register accesses are zero-wait (IBUS_BUSY tied 0)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
CE_R  in  1  rising-phase clock enable; state updates and writes
CE_F  in  1  falling-phase clock enable; register read capture
EN  in  1  block enable; arbitration frozen when 0
RES_N  in  1  synchronous soft reset (active low, sampled on CE_R)
IBUS_A  in  32  internal bus address
IBUS_DI  in  32  write data
IBUS_DO  out  32  read data
IBUS_BA  in  4  byte-lane enables
IBUS_WE  in  1  write strobe
IBUS_REQ  in  1  access request
IBUS_BUSY  out  1  wait request, always 0
IBUS_ACT  out  1  address decodes to this block
NMI_N  in  1  NMI pin, already synchronised
DIVU_IRQ, DMAC0_IRQ, DMAC1_IRQ, WDT_IRQ, SCI_IRQ, FRT_IRQ  in  1 each  peripheral level requests
DIVU_VEC, DMAC0_VEC, DMAC1_VEC, WDT_VEC, SCI_VEC, FRT_VEC  in  8 each  peripheral vector numbers
INT_MASK  in  4  CPU SR.I mask
INT_REQ  out  1  interrupt request to CPU
INT_NMI  out  1  current request is NMI
INT_LVL  out  4  level of current request
INT_VEC  out  8  vector of current request
INT_ACK  in  1  CPU accept, one CE_R pulse

Behaviour:
- Reset: RST async or RES_N low on CE_R. All regs 0, NMI pending 0, state IDLE.
  - Outputs 0: INT_REQ, INT_NMI, INT_LVL, INT_VEC, IBUS_DO.
  - NMI edge detector preloaded with the current NMI_N, so no spurious edge.
- Register map (big-endian halfwords):
  - ICR = FFFFFEE0 [31:16]. Bit15 NMIL is read-only pin level. Bit8 NMIE selects the NMI edge: 0 = falling, 1 = rising. Bit0 VECMD is stored only. Other bits read 0.
  - IPRA = FFFFFEE2 [15:0]. Fields: [15:12] DIVU, [11:8] DMAC (shared by DMAC0/1), [7:4] WDT. Bits [3:0] read 0.
  - IPRB = FFFFFE60 [31:16]. Fields: [15:12] SCI, [11:8] FRT. Bits [7:0] read 0.
- Register access:
  - IBUS_ACT = address in FFFFFEE0–FFFFFEE3 or FFFFFE60–FFFFFE63.
  - Writes on CE_R when REQ & WE & ACT, per halfword via BA[3:2] / BA[1:0].
  - Reads are captured into REG_DO on CE_F. IBUS_DO = ACT ? REG_DO : 0.
- NMI:
  - Edge detector samples NMI_N on CE_R, with EN ignored.
  - A selected edge sets NMI pending.
  - Pending is cleared only by INT_ACK while INT_NMI = 1, or by reset.
  - A new edge arriving in the same cycle as that clear takes priority: pending stays 1.
- Arbitration (combinational, evaluated on CE_R when EN = 1):
  - A candidate is any source with IRQ = 1 and priority field ≠ 0.
  - Winner is the highest field value. Ties go to the fixed order DIVU > DMAC0 > DMAC1 > WDT > SCI > FRT.
  - NMI pending beats everything: level 4'hF, INT_NMI = 1, vector NMI_VEC.
  - Peripheral requests are eligible only if level > INT_MASK. NMI ignores the mask.
- FSM, advanced on CE_R with EN = 1:
  - IDLE: if an eligible winner exists, register LVL/VEC/NMI, assert INT_REQ, go to REQ. Request latency is one CE_R after the IRQ is seen.
  - REQ: outputs frozen.
    - INT_ACK → HOLD, INT_REQ = 0.
    - Else, if the frozen source's IRQ dropped or its level is now ≤ INT_MASK (NMI excepted) → IDLE with INT_REQ = 0. This is a withdrawal.
    - A higher-priority arrival does not preempt.
  - HOLD: INT_REQ = 0 for exactly one CE_R, then IDLE. This gives the ISR time to clear the peripheral flag.
- INT_ACK in IDLE or HOLD is ignored.
- Priority register writes while in REQ do not alter the frozen LVL/VEC.
- EN = 0: FSM and outputs hold. Register writes still work.

Test Plan:
1. IPRA = 16'hA000 (DIVU = 10), INT_MASK = 3, DIVU_IRQ = 1, DIVU_VEC = 8'h50 → after one CE_R: INT_REQ = 1, INT_LVL = 4'hA, INT_VEC = 8'h50. INT_ACK → next CE_R INT_REQ = 0; after one HOLD cycle INT_REQ reasserts while DIVU_IRQ is still 1.
2. IPRA = 16'h5500 (DIVU = DMAC = 5), DIVU_IRQ and DMAC0_IRQ raised in the same cycle → INT_VEC = DIVU_VEC. Drop DIVU_IRQ → withdrawal to IDLE, then DMAC0 is presented on the next CE_R.
3. INT_MASK = 4'hF with WDT level 9 asserted → INT_REQ stays 0. NMIE = 0 and a falling edge on NMI_N → INT_REQ = 1, INT_NMI = 1, INT_LVL = 4'hF, INT_VEC = 8'd11. After ACK, pending clears and INT_REQ stays 0.
4. Write FFFFFEE2 with BA = 4'b0011, DI = 32'h0000_F0F0 → IPRA reads 16'hF0F0. Write FFFFFE60 with BA = 4'b1100, DI = 32'h1234_0000 → IPRB reads 16'h1200. Access to FFFFFF00 → IBUS_ACT = 0 and IBUS_DO = 0.
5. With INT_REQ = 1 on SCI, assert RST mid-REQ → INT_REQ, INT_LVL and INT_VEC are 0 immediately, and IPRA/IPRB read 0 afterward.
6. NMI edge arriving in the same CE_R as INT_ACK of a prior NMI → pending stays 1, and NMI is re-presented after HOLD.
